four_bit_test: RTL and testbench

- Registered 4-input Boolean function evaluator.
- Samples four single-bit inputs a, b, c, d and forms the index {d,c,b,a}, with a as LSB.
- Drives out from a 16-entry truth-table register, plus a registered population count of the inputs.
- Sits as a small leaf block; the truth table is reprogrammable at runtime and defaults to a prime-number detector.

---
 rtl/four_bit_test.sv | 69 ++++++
 tb/tb_four_bit_test.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/four_bit_test.sv
// Registered 4-input Boolean function evaluator with a runtime-reprogrammable
// 16-entry truth table and a registered population count of the inputs.
module four_bit_test #(
    parameter logic [15:0] DEFAULT_TT = 16'h28AC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        en,
    input  logic        tt_wr,
    input  logic [15:0] tt_data,
    output logic        out,
    output logic [2:0]  ones
    ,
    output logic        valid
);

    logic [15:0] truth_table_q, truth_table_d;
    logic        out_q, out_d;
    logic [2:0]  ones_q, ones_d;
    logic        valid_q, valid_d;

    logic [3:0]  idx;
    logic [15:0] table_used;

    assign idx = {d, c, b, a};

    // A write on the same edge as a sample is visible to that sample.
    assign table_used = tt_wr ? tt_data : truth_table_q;

    always_comb begin
        truth_table_d = truth_table_q;
        out_d         = out_q;
        ones_d        = ones_q;
        valid_d       = valid_q;

        if (tt_wr) begin
            truth_table_d = tt_data;
        end

        if (en) begin
            out_d   = table_used[idx];
            ones_d  = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            truth_table_q <= DEFAULT_TT;
            out_q         <= 1'b0;
            ones_q        <= 3'd0;
            valid_q       <= 1'b0;
        end else begin
            truth_table_q <= truth_table_d;
            out_q         <= out_d;
            ones_q        <= ones_d;
            valid_q       <= valid_d;
        end
    end

    assign out   = out_q;
    assign ones  = ones_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_four_bit_test.sv
// Self-checking bench for four_bit_test: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the truth-table evaluator.
module tb_four_bit_test;

    logic        clk;
    logic        rst_n;
    logic        a, b, c, d;
    logic        en;
    logic        tt_wr;
    logic [15:0] tt_data;
    logic        out;
    logic [2:0]  ones;
    logic        valid;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [15:0] m_tt;
    logic        m_out;
    logic [2:0]  m_ones;
    logic        m_valid;

    four_bit_test dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .en      (en),
        .tt_wr   (tt_wr),
        .tt_data (tt_data),
        .out     (out),
        .ones    (ones),
        .valid   (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached (actual=timeout required=finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k * k <= n; k++) begin
            if (n % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_tt    = 16'h28AC;
        m_out   = 1'b0;
        m_ones  = 3'd0;
        m_valid = 1'b0;
    endtask

    // Drive one clock's worth of inputs, advance the model, then sample #1 after the edge.
    task automatic step(input logic en_i, input logic [3:0] idx_i,
                        input logic wr_i, input logic [15:0] data_i);
        logic [15:0] used;
        en      = en_i;
        {d, c, b, a} = idx_i;
        tt_wr   = wr_i;
        tt_data = data_i;
        used    = wr_i ? data_i : m_tt;
        if (en_i) begin
            m_out   = used[idx_i];
            m_ones  = 3'($countones(idx_i));
            m_valid = 1'b1;
        end
        if (wr_i) m_tt = data_i;
        @(posedge clk);
        #1;
        en    = 1'b0;
        tt_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0; tt_wr = 1'b0; tt_data = 16'h0;
        {d, c, b, a} = 4'h0;
        model_reset();
        #1;
        checks++;
        if ({out, ones, valid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: out=%b ones=%0d valid=%b required all zero", out, ones, valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 4'hF, 1'b0, 16'h0);
        checks++;
        if (valid !== 1'b0 || out !== 1'b0 || ones !== 3'd0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: out=%b ones=%0d valid=%b required 0/0/0", out, ones, valid);
        end
    endtask

    task automatic test_default_sweep();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 1'b0, 16'h0);
            checks++;
            if (out !== is_prime(i) || ones !== 3'($countones(4'(i))) || valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL default_sweep idx=%0d: out=%b ones=%0d valid=%b required %b/%0d/1",
                         i, out, ones, valid, is_prime(i), $countones(4'(i)));
            end
        end
    endtask

    task automatic test_hold();
        step(1'b1, 4'd3, 1'b0, 16'h0);
        checks++;
        if (out !== 1'b1 || ones !== 3'd2) begin
            errors++;
            $display("[TB] FAIL hold_setup: out=%b ones=%0d required 1/2", out, ones);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'd8, 1'b0, 16'h0);
            checks++;
            if (out !== 1'b1 || ones !== 3'd2 || valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: out=%b ones=%0d valid=%b required 1/2/1", k, out, ones, valid);
            end
        end
        step(1'b1, 4'd8, 1'b0, 16'h0);
        checks++;
        if (out !== 1'b0 || ones !== 3'd1) begin
            errors++;
            $display("[TB] FAIL hold_release: out=%b ones=%0d required 0/1", out, ones);
        end
    endtask

    task automatic test_reprogram();
        step(1'b0, 4'd0, 1'b1, 16'h8001);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 1'b0, 16'h0);
            checks++;
            if (out !== ((i == 0 || i == 15) ? 1'b1 : 1'b0) || out !== m_out) begin
                errors++;
                $display("[TB] FAIL reprogram_sweep idx=%0d: out=%b required %b", i, out, m_out);
            end
        end
    endtask

    task automatic test_write_through();
        step(1'b1, 4'd4, 1'b1, 16'hFFFF);
        checks++;
        if (out !== 1'b1 || ones !== 3'd1) begin
            errors++;
            $display("[TB] FAIL write_through: out=%b ones=%0d required 1/1", out, ones);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 4'd13, 1'b1, 16'h0000);
        checks++;
        if (out !== 1'b0 || ones !== 3'd3) begin
            errors++;
            $display("[TB] FAIL program_zero: out=%b ones=%0d required 0/3", out, ones);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({out, ones, valid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: out=%b ones=%0d valid=%b required all zero", out, ones, valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 4'd13, 1'b0, 16'h0);
        checks++;
        if (out !== 1'b1 || ones !== 3'd3 || valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL default_restored: out=%b ones=%0d valid=%b required 1/3/1", out, ones, valid);
        end
    endtask

    task automatic test_glitch();
        step(1'b1, 4'd0, 1'b0, 16'h0);
        en = 1'b1;
        c  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a = ~a;
            #1;
            checks++;
            if (out !== 1'b0 || ones !== 3'd0) begin
                errors++;
                $display("[TB] FAIL glitch_between_edges k=%0d: out=%b ones=%0d required 0/0", k, out, ones);
            end
        end
        step(1'b1, 4'd5, 1'b0, 16'h0);
        checks++;
        if (out !== 1'b1 || ones !== 3'd2) begin
            errors++;
            $display("[TB] FAIL glitch_settled: out=%b ones=%0d required 1/2", out, ones);
        end
    endtask

    task automatic test_random();
        logic        r_en, r_wr;
        logic [3:0]  r_idx;
        logic [15:0] r_data;
        for (int n = 0; n < 300; n++) begin
            r_en   = 1'($urandom_range(0, 3) != 0);
            r_wr   = 1'($urandom_range(0, 7) == 0);
            r_idx  = 4'($urandom);
            r_data = 16'($urandom);
            step(r_en, r_idx, r_wr, r_data);
            checks++;
            if (out !== m_out || ones !== m_ones || valid !== m_valid) begin
                errors++;
                $display("[TB] FAIL random n=%0d idx=%0d en=%b wr=%b: out=%b ones=%0d valid=%b required %b/%0d/%b",
                         n, r_idx, r_en, r_wr, out, ones, valid, m_out, m_ones, m_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_sweep();
        test_hold();
        test_reprogram();
        test_write_through();
        test_async_reset();
        test_glitch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
